// File: rtl/dram_arbiter_pkg.sv
// Shared configuration and types for the data-RAM arbiter.
//   dram_depth          : RAM word-address width
//   dram_req_type       : registered request (word addr, wdata, wstrb, owner, range error)
//   dram_arb_state_type : sequencer states
package configure;

  localparam int unsigned dram_depth = 10;

  typedef struct packed {
    logic [dram_depth-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  owner;
    logic                  err;
  } dram_req_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dram_arb_state_type;

  // Byte address to RAM word address; addr[1:0] is dropped.
  function automatic logic [dram_depth-1:0] word_addr(input logic [31:0] a);
    return a[dram_depth+1:2];
  endfunction

  // Any address bit above the RAM window flags an out-of-range access.
  function automatic logic addr_err(input logic [31:0] a);
    return |a[31:dram_depth+2];
  endfunction

endpackage

// File: rtl/dram_arbiter_rr_arb.sv
// Combinational 2-way round-robin pick.
//   i_req          : eligible (already masked) requests
//   i_last_grant   : index granted most recently
//   o_gnt_valid_c  : some request is granted
//   o_gnt_idx_c    : granted index
module dram_rr_arb (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_gnt_valid_c,
  output logic       o_gnt_idx_c
);

  // On a tie the requester that did not win last time is picked.
  always_comb begin
    o_gnt_valid_c = |i_req;
    o_gnt_idx_c   = 1'b0;
    if (&i_req) begin
      o_gnt_idx_c = ~i_last_grant;
    end else begin
      o_gnt_idx_c = i_req[1];
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Two-master arbiter and sequencer in front of the synchronous data RAM.
//   clk, rst              : clock, synchronous active-low reset
//   mN_valid/addr/wdata/wstrb : master request (wstrb 0 = read)
//   mN_rdata/mN_ready     : completion pulse and read data
//   dram_*                : RAM write/read ports (1-cycle registered read)
module dram_arbiter
  import configure::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_valid,
  input  logic [31:0]           m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic [31:0]           m0_rdata,
  output logic                  m0_ready,
  input  logic                  m1_valid,
  input  logic [31:0]           m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic [31:0]           m1_rdata,
  output logic                  m1_ready,
  output logic                  dram_wen,
  output logic [dram_depth-1:0] dram_waddr,
  output logic [dram_depth-1:0] dram_raddr,
  output logic [31:0]           dram_wdata,
  output logic [3:0]            dram_wstrb,
  input  logic [31:0]           dram_rdata
);

  dram_arb_state_type r_state, w_next_state;
  dram_req_type       r_req, w_new_req;
  logic               r_last_grant;
  logic               r_wen, w_wen_next;
  logic [3:0]         r_wstrb, w_wstrb_next;
  logic [1:0]         r_ready, w_ready_next;
  logic [1:0]         w_elig;
  logic               w_gnt_valid, w_gnt_idx;
  logic               w_rd_ok;
  logic               w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

  // No grant during ACCESS; in RESP the current owner is still holding valid.
  always_comb begin
    w_elig = 2'b00;
    if (r_state != ACCESS) begin
      w_elig[0] = m0_valid & ~((r_state == RESP) & (r_req.owner == 1'b0));
      w_elig[1] = m1_valid & ~((r_state == RESP) & (r_req.owner == 1'b1));
    end
  end

  dram_rr_arb u_rr_arb (
    .i_req         (w_elig),
    .i_last_grant  (r_last_grant),
    .o_gnt_valid_c (w_gnt_valid),
    .o_gnt_idx_c   (w_gnt_idx)
  );

  // Next state, next request capture and next registered RAM/master controls.
  always_comb begin
    w_next_state = r_state;
    w_new_req    = '0;
    w_wen_next   = 1'b0;
    w_wstrb_next = 4'h0;
    w_ready_next = 2'b00;

    w_new_req.addr  = word_addr(w_gnt_idx ? m1_addr : m0_addr);
    w_new_req.wdata = w_gnt_idx ? m1_wdata : m0_wdata;
    w_new_req.wstrb = w_gnt_idx ? m1_wstrb : m0_wstrb;
    w_new_req.owner = w_gnt_idx;
    w_new_req.err   = addr_err(w_gnt_idx ? m1_addr : m0_addr);

    case (r_state)
      IDLE:    if (w_gnt_valid) w_next_state = ACCESS;
      ACCESS:  w_next_state = RESP;
      RESP:    w_next_state = w_gnt_valid ? ACCESS : IDLE;
      default: w_next_state = IDLE;
    endcase

    if (w_gnt_valid) begin
      w_wen_next   = (|w_new_req.wstrb) & ~w_new_req.err;
      w_wstrb_next = w_new_req.wstrb;
    end

    if (r_state == ACCESS) begin
      w_ready_next = r_req.owner ? 2'b10 : 2'b01;
    end
  end

  // State, request and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_last_grant <= 1'b1;
      r_wen        <= 1'b0;
      r_wstrb      <= 4'h0;
      r_ready      <= 2'b00;
    end else begin
      r_state <= w_next_state;
      if (w_gnt_valid) begin
        r_req        <= w_new_req;
        r_last_grant <= w_gnt_idx;
      end
      r_wen   <= w_wen_next;
      r_wstrb <= w_wstrb_next;
      r_ready <= w_ready_next;
    end
  end

  // Request register is stable through RESP, so it qualifies the RAM read data.
  assign w_rd_ok = (r_req.wstrb == 4'h0) & ~r_req.err;

  assign m0_ready   = r_ready[0];
  assign m1_ready   = r_ready[1];
  assign m0_rdata   = (r_ready[0] & w_rd_ok) ? dram_rdata : 32'h0;
  assign m1_rdata   = (r_ready[1] & w_rd_ok) ? dram_rdata : 32'h0;
  assign dram_wen   = r_wen;
  assign dram_wstrb = r_wstrb;
  assign dram_waddr = r_req.addr;
  assign dram_raddr = r_req.addr;
  assign dram_wdata = r_req.wdata;

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-requester arbiter and sequencer in front of the synchronous data RAM (`dram`: 1-cycle registered read, byte-strobed write, `dram_depth`-bit word address). It accepts byte-addressed valid/ready requests from two masters, such as the core data port and a debug/loader port. It grants one request at a time with round-robin fairness, drives the RAM write/read ports from registered request state, and returns read data with a single-cycle `ready` pulse to the owner.

## Interface
Parameters:
- `dram_depth`, taken from package `configure`, not a module parameter: RAM word-address width.

Ports (N = 0, 1). Clock is `clk`; reset is `rst`, synchronous, active-low.
- `clk`  in  1  clock, all logic on posedge
- `rst`  in  1  synchronous active-low reset
- `mN_valid`  in  1  request pending; held high until `mN_ready`
- `mN_addr`  in  32  byte address
- `mN_wdata`  in  32  write data
- `mN_wstrb`  in  4  byte strobes; 0 = read
- `mN_rdata`  out  32  read data; valid only while `mN_ready`=1, otherwise 0
- `mN_ready`  out  1  one-cycle completion pulse
- `dram_wen`  out  1  RAM write enable
- `dram_waddr`  out  `dram_depth`  RAM write word address
- `dram_raddr`  out  `dram_depth`  RAM read word address
- `dram_wdata`  out  32  RAM write data
- `dram_wstrb`  out  4  RAM byte strobes
- `dram_rdata`  in  32  RAM registered read data

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **Request register:** holds addr, wdata, wstrb, owner, and a range-error flag; loaded on every grant.
- **Grant:** a grant happens in IDLE, or in RESP, when an eligible `mN_valid`=1.
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one that is not `last_grant`.
  - `last_grant` updates on every grant.
- **Eligibility in RESP:** the current owner is masked, because its `valid` is still high during its `ready` cycle. Only the other requester can be granted there.
- **Transitions:**
  - IDLE → ACCESS on grant.
  - ACCESS → RESP always.
  - RESP → ACCESS on grant; otherwise RESP → IDLE.
- **Address mapping:** word address = `addr[dram_depth+1:2]`; `addr[1:0]` is ignored.
- **Range error:** set when `addr[31:dram_depth+2]` ≠ 0.
- **ACCESS:**
  - `dram_raddr` = `dram_waddr` = registered word address.
  - `dram_wen` = 1 iff wstrb ≠ 0 and no range error.
  - `dram_wstrb` and `dram_wdata` come from the register.
- **RESP:**
  - Owner's `ready` = 1.
  - Owner's `rdata` = `dram_rdata` for an in-range read; 0 for a write or a range error.
  - The non-owner sees `ready` = 0 and `rdata` = 0.
- **Outside ACCESS:** `dram_wen` = 0, `dram_wstrb` = 0; addresses and wdata hold their last values.
- **Reset (`rst`=0 at posedge, including mid-transaction):**
  - State → IDLE, `last_grant` → 1 (m0 wins the first tie), request register cleared.
  - Any pending response is dropped with no `ready`; the master must re-issue.
  - Outputs during and after reset: all `mN_ready`=0, `mN_rdata`=0, `dram_wen`=0, `dram_wstrb`=0, `dram_waddr`=0, `dram_raddr`=0, `dram_wdata`=0.
- **Master behaviour:** changing addr/wdata/wstrb while valid is high and before `ready` is illegal; the arbiter samples them only at grant.

## Timing
- **Latency:** a request granted at edge T has RAM port drive in cycle T+1 (ACCESS) and `ready` in cycle T+2 (RESP). That is 2 cycles from grant to `ready`, and 3 cycles for a request arriving in IDLE, counting the arrival cycle.
- **Throughput:** one transaction per 2 cycles when requests are back-to-back (RESP → ACCESS).
- **Alternating service:** with both masters continuously valid, they alternate, and each completes once every 4 cycles.
- **Single master:** a master issuing back-to-back requests alone (the other idle) gets one transaction per 3 cycles. Its new request, after valid drops for one cycle, is granted in the next IDLE or RESP.
- **Write-then-read:** a write followed by a read of the same address returns the new data, because the write commits at the end of ACCESS and the read's ACCESS is at least 2 cycles later.

## Structure
- Package `configure`:
  - `dram_depth` (existing).
  - New typedef `dram_req_type` (struct: addr, wdata, wstrb, owner, err).
  - New enum `dram_arb_state_type` (IDLE, ACCESS, RESP).
- Sub-module `dram_rr_arb`: combinational 2-way round-robin pick. Inputs: masked requests and `last_grant`. Outputs: grant valid and grant index. `last_grant` is registered in `dram_arbiter`.
- `dram_arbiter` instantiates `dram_rr_arb`; its `dram_*` ports connect directly to `dram`.

## Test plan
- **Reset mid-op:** m0 read in ACCESS, `rst`=0 for 1 cycle → no `m0_ready`, `dram_wen`=0, state IDLE; the re-issued read then completes normally.
- **Write then read:** m0 writes 0xDEADBEEF, wstrb=0xF, addr 0x10 → `ready` 2 cycles after grant, `rdata`=0. m0 then reads addr 0x10 → `rdata`=0xDEADBEEF.
- **Byte strobes:** write 0x000000AA wstrb=0x1, then 0x0000BB00 wstrb=0x2 to a word holding 0x11223344 → a read returns 0x1122BBAA.
- **Contention:** m0 and m1 both valid from reset, holding continuously → grants m0, m1, m0, m1; `ready` every 2 cycles, alternating owner; no requester is granted twice in a row.
- **RESP masking:** m0 alone keeps valid high through its `ready` cycle → no second grant that cycle, state goes to IDLE. A new m0 request is served afterwards.
- **Out of range:** read at `addr` = 1<<(dram_depth+2) → `ready` after 2 cycles, `rdata`=0. A write to the same address → `dram_wen` never 1, RAM unchanged.
